io_out_uart_tx: RTL

//  I/O-side responder for the core's output port (out_issued/out_data/out_stall).

---
 rtl/io_out_uart_tx.sv | 215 +++++++++++++++++++++
 1 files changed

// File: rtl/io_out_uart_tx.sv
// Output-port responder: queues bytes from the core and serialises them as 8N1 UART frames.
// Optional even-parity bit after the data bits when IO_OUT_PARITY_EN is defined (8E1 frame).
module io_out_uart_tx #(
   parameter int CLKS_PER_BIT = 868,
   parameter int DEPTH        = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     out_issued,
   input  logic [31:0]              out_data,
   output logic                     out_stall,
   output logic                     tx,
   output logic                     tx_busy,
   output logic [$clog2(DEPTH):0]   fifo_count,
   output logic [31:0]              sent_bytes
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam int BW = $clog2(CLKS_PER_BIT);

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4
   } state_t;

   function automatic logic even_parity(input logic [7:0] b);
      return ^b;
   endfunction

   logic [7:0]    mem_r [DEPTH];
   logic [AW-1:0] wr_ptr_r;
   logic [AW-1:0] rd_ptr_r;
   logic [CW-1:0] count_r;
   logic [CW-1:0] count_n_s;
   logic          stall_r;
   logic          push_s;
   logic          pop_s;

   state_t        state_r;
   state_t        state_n_s;
   logic [BW-1:0] baud_r;
   logic [BW-1:0] baud_n_s;
   logic [2:0]    bit_r;
   logic [2:0]    bit_n_s;
   logic [7:0]    shift_r;
   logic [7:0]    shift_n_s;
   logic          par_r;
   logic          par_n_s;
   logic          baud_end_s;
   logic          frame_done_s;
   logic          tx_r;
   logic          tx_n_s;
   logic          busy_r;
   logic [31:0]   sent_r;
   logic          unused_data_s;

   assign unused_data_s = ^out_data[31:8];

   // The full flag is registered, so a push is never qualified by this cycle's pop.
   assign push_s     = out_issued & ~stall_r;
   assign baud_end_s = (baud_r == BW'(CLKS_PER_BIT - 1));

   // Next occupancy from push/pop
   always_comb begin
      count_n_s = count_r;
      case ({push_s, pop_s})
         2'b10:   count_n_s = count_r + CW'(1);
         2'b01:   count_n_s = count_r - CW'(1);
         default: count_n_s = count_r;
      endcase
   end

   // FIFO storage, pointers, occupancy and full flag
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_r[i] <= 8'h00;
         end
         wr_ptr_r <= '0;
         rd_ptr_r <= '0;
         count_r  <= '0;
         stall_r  <= 1'b0;
      end else begin
         if (push_s) begin
            mem_r[wr_ptr_r] <= out_data[7:0];
            wr_ptr_r        <= wr_ptr_r + AW'(1);
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + AW'(1);
         end
         count_r <= count_n_s;
         stall_r <= (count_n_s == CW'(DEPTH));
      end
   end

   // Shifter FSM: next state, baud/bit counters, shift register and pop
   always_comb begin
      state_n_s    = state_r;
      baud_n_s     = baud_r;
      bit_n_s      = bit_r;
      shift_n_s    = shift_r;
      par_n_s      = par_r;
      pop_s        = 1'b0;
      frame_done_s = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (count_r != CW'(0)) begin
               pop_s     = 1'b1;
               shift_n_s = mem_r[rd_ptr_r];
               par_n_s   = even_parity(mem_r[rd_ptr_r]);
               baud_n_s  = '0;
               bit_n_s   = 3'd0;
               state_n_s = ST_START;
            end else begin
               state_n_s = ST_IDLE;
            end
         end
         ST_START: begin
            if (baud_end_s) begin
               baud_n_s  = '0;
               state_n_s = ST_DATA;
            end else begin
               baud_n_s  = baud_r + BW'(1);
            end
         end
         ST_DATA: begin
            if (baud_end_s) begin
               baud_n_s  = '0;
               shift_n_s = {1'b0, shift_r[7:1]};
               if (bit_r == 3'd7) begin
                  bit_n_s = 3'd0;
`ifdef IO_OUT_PARITY_EN
                  state_n_s = ST_PARITY;
`else
                  state_n_s = ST_STOP;
`endif
               end else begin
                  bit_n_s = bit_r + 3'd1;
               end
            end else begin
               baud_n_s = baud_r + BW'(1);
            end
         end
         ST_PARITY: begin
            if (baud_end_s) begin
               baud_n_s  = '0;
               state_n_s = ST_STOP;
            end else begin
               baud_n_s  = baud_r + BW'(1);
            end
         end
         ST_STOP: begin
            if (baud_end_s) begin
               baud_n_s     = '0;
               frame_done_s = 1'b1;
               state_n_s    = ST_IDLE;
            end else begin
               baud_n_s     = baud_r + BW'(1);
            end
         end
         default: begin
            baud_n_s  = '0;
            bit_n_s   = 3'd0;
            state_n_s = ST_IDLE;
         end
      endcase
   end

   // Line level for the current state; registered below so tx trails the state by one cycle
   always_comb begin
      tx_n_s = 1'b1;
      case (state_r)
         ST_START:  tx_n_s = 1'b0;
         ST_DATA:   tx_n_s = shift_r[0];
         ST_PARITY: tx_n_s = par_r;
         default:   tx_n_s = 1'b1;
      endcase
   end

   // Shifter state, counters and registered outputs
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r <= ST_IDLE;
         baud_r  <= '0;
         bit_r   <= 3'd0;
         shift_r <= 8'h00;
         par_r   <= 1'b0;
         tx_r    <= 1'b1;
         busy_r  <= 1'b0;
         sent_r  <= 32'd0;
      end else begin
         state_r <= state_n_s;
         baud_r  <= baud_n_s;
         bit_r   <= bit_n_s;
         shift_r <= shift_n_s;
         par_r   <= par_n_s;
         tx_r    <= tx_n_s;
         busy_r  <= (state_n_s != ST_IDLE);
         if (frame_done_s) begin
            sent_r <= sent_r + 32'd1;
         end
      end
   end

   assign out_stall  = stall_r;
   assign tx         = tx_r;
   assign tx_busy    = busy_r;
   assign fifo_count = count_r;
   assign sent_bytes = sent_r;

endmodule
